// File: rtl/display_scan_controller.sv
// display_scan_controller
//   Multiplexed driver for a 4-digit, 7-segment hex display. Each digit gets
//   a short all-off dead time followed by a lit slot whose duty cycle follows
//   a 4-bit brightness level. A new 16-bit value is double-buffered and only
//   reaches the display at a frame boundary, so a frame never shows a mix of
//   old and new digits.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   value[15:0]  four hex nibbles, [3:0] is digit 0
//   load         request to take value (see handshake note below)
//   ready        high when a new value can be accepted
//   blank_lz     blank leading zeros on digits 1..3 (sampled at frame boundary)
//   brightness   duty level 0..15 (sampled at frame boundary)
//   segment[6:0] active-high segments, bit0=a .. bit6=g (registered)
//   indicator    active-low digit selects, 4'b1110 = digit 0 (registered)
//   frame_pulse  one-cycle pulse in the cycle after each frame boundary
//
// Handshake: a transfer happens on a rising edge where load=1 and ready=1.
// ready then stays low until the pending value has been moved to the display
// at the next frame boundary; load while ready=0 is ignored.

module display_scan_controller #(
   parameter int SLOT_CYCLES = 1024,
   parameter int DEAD_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] value,
   input  logic        load,
   output logic        ready,
   input  logic        blank_lz,
   input  logic [3:0]  brightness,
   output logic [6:0]  segment,
   output logic [3:0]  indicator,
   output logic        frame_pulse
);

   localparam int MAXC = (SLOT_CYCLES > DEAD_CYCLES) ? SLOT_CYCLES : DEAD_CYCLES;
   localparam int PW   = $clog2(MAXC);
   localparam logic [PW-1:0] SLOT_LAST = PW'(SLOT_CYCLES - 1);
   localparam logic [PW-1:0] DEAD_LAST = PW'(DEAD_CYCLES - 1);
   localparam int unsigned   STEP      = SLOT_CYCLES / 16;

   typedef enum logic {BLANK = 1'b0, LIT = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [1:0]      digit_q, digit_d;
   logic [PW-1:0]   phase_q, phase_d;

   logic [15:0]     disp_q, pend_q;
   logic            ready_q;
   logic [3:0]      bright_f;
   logic            blz_f;

   logic            frame_end;
   logic [3:0]      nib;
   logic            lz_blank;
   logic [31:0]     on_limit;
   logic            drive;
   logic [6:0]      seg_d;
   logic [3:0]      ind_d;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
         4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
         4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
         4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
      endcase
      return s;
   endfunction

   // ---------------- scan FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BLANK;
         digit_q <= 2'd0;
         phase_q <= '0;
      end else begin
         state_q <= state_d;
         digit_q <= digit_d;
         phase_q <= phase_d;
      end
   end

   always_comb begin
      state_d = state_q;
      digit_d = digit_q;
      phase_d = phase_q + 1'b1;
      case (state_q)
         BLANK: begin
            if (phase_q == DEAD_LAST) begin
               state_d = LIT;
               phase_d = '0;
            end
         end
         LIT: begin
            if (phase_q == SLOT_LAST) begin
               state_d = BLANK;
               digit_d = digit_q + 2'd1;
               phase_d = '0;
            end
         end
         default: begin
            state_d = BLANK;
            phase_d = '0;
         end
      endcase
   end

   // Last lit cycle of digit 3: everything sampled "per frame" updates here.
   assign frame_end = (state_q == LIT) && (digit_q == 2'd3) && (phase_q == SLOT_LAST);

   // ---------------- value buffering ----------------
   // pend_valid is the complement of ready_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_q   <= 16'h0000;
         pend_q   <= 16'h0000;
         ready_q  <= 1'b1;
         bright_f <= 4'hF;
         blz_f    <= 1'b0;
      end else begin
         // Accept and transfer are exclusive: a transfer needs ready_q=0.
         // A load taken in the boundary cycle therefore waits a full frame.
         if (load && ready_q) begin
            pend_q  <= value;
            ready_q <= 1'b0;
         end else if (frame_end && !ready_q) begin
            disp_q  <= pend_q;
            ready_q <= 1'b1;
         end
         if (frame_end) begin
            bright_f <= brightness;
            blz_f    <= blank_lz;
         end
      end
   end

   assign ready = ready_q;

   // ---------------- digit output ----------------
   always_comb begin
      nib      = disp_q[3:0];
      lz_blank = 1'b0;
      case (digit_q)
         2'd1: begin nib = disp_q[7:4];   lz_blank = (disp_q[15:4]  == 12'h000); end
         2'd2: begin nib = disp_q[11:8];  lz_blank = (disp_q[15:8]  == 8'h00);   end
         2'd3: begin nib = disp_q[15:12]; lz_blank = (disp_q[15:12] == 4'h0);    end
         default: begin nib = disp_q[3:0]; lz_blank = 1'b0; end
      endcase
   end

   // Lit duty: (brightness_f+1)/16 of the slot, starting at phase 0.
   assign on_limit = (32'(bright_f) + 32'd1) * STEP;
   assign drive    = (state_q == LIT) && (32'(phase_q) < on_limit) && !(blz_f && lz_blank);
   assign seg_d    = drive ? hex7(nib) : 7'h00;
   assign ind_d    = drive ? ~(4'b0001 << digit_q) : 4'b1111;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         segment     <= 7'h00;
         indicator   <= 4'b1111;
         frame_pulse <= 1'b0;
      end else begin
         segment     <= seg_d;
         indicator   <= ind_d;
         frame_pulse <= frame_end;
      end
   end

endmodule

// File: tb/tb_display_scan_controller.sv
// Testbench for display_scan_controller with SLOT_CYCLES=16, DEAD_CYCLES=2
// (72-cycle frame). Outputs are sampled on the falling edge; inputs are also
// changed on the falling edge so they are stable at the next rising edge.
// Within a frame, t=0 is the falling edge where frame_pulse is seen high;
// t=1..72 follow, with t=72 carrying the next frame_pulse.

module tb_display_scan_controller;

   localparam int SLOT  = 16;
   localparam int DEAD  = 2;
   localparam int DSLOT = DEAD + SLOT;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] value;
   logic        load;
   logic        ready;
   logic        blank_lz;
   logic [3:0]  brightness;
   logic [6:0]  segment;
   logic [3:0]  indicator;
   logic        frame_pulse;

   int tests_run    = 0;
   int tests_failed = 0;

   // bench-side view of what the display should hold
   logic [15:0] disp_m, pend_m;
   logic        rdy_m;
   logic [3:0]  bf_m;
   logic        blz_m;

   logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   display_scan_controller #(.SLOT_CYCLES(SLOT), .DEAD_CYCLES(DEAD)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .value       (value),
      .load        (load),
      .ready       (ready),
      .blank_lz    (blank_lz),
      .brightness  (brightness),
      .segment     (segment),
      .indicator   (indicator),
      .frame_pulse (frame_pulse)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
      $fatal(1);
   end

   // ---------------- helpers ----------------
   task automatic model_reset();
      disp_m = 16'h0000;
      pend_m = 16'h0000;
      rdy_m  = 1'b1;
      bf_m   = 4'hF;
      blz_m  = 1'b0;
   endtask

   task automatic expected_at(input int t, output logic [3:0] ind,
                              output logic [6:0] seg, output logic fp);
      int          idx, r;
      logic [15:0] sh;
      logic [3:0]  nb;
      logic        drv;
      idx = (t - 1) / DSLOT;
      r   = (t - 1) % DSLOT;
      fp  = (t == 4 * DSLOT);
      sh  = disp_m >> (4 * idx);
      nb  = sh[3:0];
      drv = (r >= DEAD) && ((r - DEAD) < (int'(bf_m) + 1) * (SLOT / 16));
      if (blz_m && idx >= 1 && sh == 16'h0000) drv = 1'b0;
      ind = drv ? ~(4'b0001 << idx) : 4'b1111;
      seg = drv ? hex_tab[nb] : 7'h00;
   endtask

   // Wait for a frame_pulse (bounded) and account for its boundary.
   task automatic sync_frame();
      bit found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (frame_pulse === 1'b1) found = 1'b1;
      end
      tests_run++;
      if (!found) begin
         tests_failed++;
         $display("FAIL sync_frame: frame_pulse got never high, want high within 200 cycles");
      end
      bf_m  = brightness;
      blz_m = blank_lz;
   endtask

   // Run one full frame starting at t=0, checking every cycle. Loads are
   // driven at the falling edge after step lt1/lt2 (-1 = none), brightness
   // is changed at step bt (-1 = none).
   task automatic run_frame(input string name,
                            input int lt1, input logic [15:0] lv1,
                            input int lt2, input logic [15:0] lv2,
                            input int bt,  input logic [3:0] bv);
      logic [3:0] e_ind;
      logic [6:0] e_seg;
      logic       e_fp;
      logic       rdy_old;
      for (int t = 0; t <= 4 * DSLOT; t++) begin
         if (t > 0) begin
            @(negedge clk);
            expected_at(t, e_ind, e_seg, e_fp);
            rdy_old = rdy_m;
            if (load && rdy_old) begin
               pend_m = value;
               rdy_m  = 1'b0;
            end
            if (t == 4 * DSLOT) begin
               if (!rdy_old) begin
                  disp_m = pend_m;
                  rdy_m  = 1'b1;
               end
               bf_m  = brightness;
               blz_m = blank_lz;
            end
            tests_run++;
            if (indicator !== e_ind || segment !== e_seg ||
                frame_pulse !== e_fp || ready !== rdy_m) begin
               tests_failed++;
               $display("FAIL %s t=%0d: got ind=%b seg=%h fp=%b rdy=%b, want ind=%b seg=%h fp=%b rdy=%b",
                        name, t, indicator, segment, frame_pulse, ready,
                        e_ind, e_seg, e_fp, rdy_m);
            end
         end
         load = 1'b0;
         if (t == lt1) begin load = 1'b1; value = lv1; end
         if (t == lt2) begin load = 1'b1; value = lv2; end
         if (t == bt) brightness = bv;
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n      = 1'b0;
      load       = 1'b0;
      value      = 16'h0000;
      blank_lz   = 1'b0;
      brightness = 4'hF;
      model_reset();
      repeat (3) @(negedge clk);
      tests_run++;
      if (indicator !== 4'b1111) begin tests_failed++; $display("FAIL reset_indicator: got %b want 1111", indicator); end
      tests_run++;
      if (segment !== 7'h00) begin tests_failed++; $display("FAIL reset_segment: got %h want 00", segment); end
      tests_run++;
      if (frame_pulse !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_pulse: got %b want 0", frame_pulse); end
      tests_run++;
      if (ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", ready); end
      rst_n = 1'b1;
      @(negedge clk);
      tests_run++;
      if (indicator !== 4'b1111 || frame_pulse !== 1'b0) begin
         tests_failed++;
         $display("FAIL first_cycle_blank: got ind=%b fp=%b want ind=1111 fp=0", indicator, frame_pulse);
      end
   endtask

   task automatic test_free_run();
      sync_frame();
      run_frame("free_run", -1, 16'h0, -1, 16'h0, -1, 4'h0);
   endtask

   task automatic test_load();
      run_frame("load_mid",  30, 16'h12AF, -1, 16'h0, -1, 4'h0);
      run_frame("show_12af", -1, 16'h0,    -1, 16'h0, -1, 4'h0);
   endtask

   task automatic test_blank_lz();
      blank_lz = 1'b1;
      run_frame("lz_load",   10, 16'h0005, -1, 16'h0, -1, 4'h0);
      run_frame("lz_0005",    5, 16'h0000, -1, 16'h0, -1, 4'h0);
      run_frame("lz_0000",   -1, 16'h0,    -1, 16'h0, -1, 4'h0);
      blank_lz = 1'b0;
      run_frame("lz_off",    -1, 16'h0,    -1, 16'h0, -1, 4'h0);
   endtask

   task automatic test_brightness();
      run_frame("bright_set", 20, 16'hC3E9, -1, 16'h0,  0, 4'd3);
      run_frame("bright_3",   -1, 16'h0,    -1, 16'h0, 20, 4'd9);
      run_frame("bright_9",   -1, 16'h0,    -1, 16'h0,  0, 4'd0);
      run_frame("bright_0",   -1, 16'h0,    -1, 16'h0,  0, 4'd15);
      run_frame("bright_15",  -1, 16'h0,    -1, 16'h0, -1, 4'h0);
   endtask

   task automatic test_back_to_back();
      run_frame("two_loads",     10, 16'h4321, 40, 16'h9999, -1, 4'h0);
      run_frame("boundary_load", 71, 16'h8765, -1, 16'h0,    -1, 4'h0);
      run_frame("still_4321",    20, 16'h1111, -1, 16'h0,    -1, 4'h0);
      run_frame("show_8765",     -1, 16'h0,    -1, 16'h0,    -1, 4'h0);
   endtask

   task automatic test_reset_mid();
      // at t=0 of a frame: start a handshake, then reset inside digit 1's LIT
      load  = 1'b1;
      value = 16'hBEEF;
      @(negedge clk);
      load = 1'b0;
      repeat (29) @(negedge clk);
      tests_run++;
      if (ready !== 1'b0) begin tests_failed++; $display("FAIL mid_ready_low: got %b want 0", ready); end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (indicator !== 4'b1111) begin tests_failed++; $display("FAIL async_indicator: got %b want 1111", indicator); end
      tests_run++;
      if (segment !== 7'h00) begin tests_failed++; $display("FAIL async_segment: got %h want 00", segment); end
      tests_run++;
      if (frame_pulse !== 1'b0) begin tests_failed++; $display("FAIL async_frame_pulse: got %b want 0", frame_pulse); end
      tests_run++;
      if (ready !== 1'b1) begin tests_failed++; $display("FAIL async_ready: got %b want 1", ready); end
      model_reset();
      brightness = 4'hF;
      blank_lz   = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      sync_frame();
      run_frame("post_reset_1", -1, 16'h0, -1, 16'h0, -1, 4'h0);
      run_frame("post_reset_2", -1, 16'h0, -1, 16'h0, -1, 4'h0);
   endtask

   // ---------------- sequence ----------------
   initial begin
      test_reset();
      test_free_run();
      test_load();
      test_blank_lz();
      test_brightness();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/display_scan_controller.md
DISPLAY_SCAN_CONTROLLER -- requirements
Module: display_scan_controller

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-low reset. Flops SHALL be clocked on the rising edge of clk and cleared immediately when rst_n falls.
REQ-002 Parameter SLOT_CYCLES, default 1024: number of lit-phase cycles per digit. It SHALL be a multiple of 16 and at least 16.
REQ-003 Parameter DEAD_CYCLES, default 16: number of all-off cycles before each digit. It SHALL be at least 1.
REQ-004 clk  input  1  system clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 value  input  16  four hex nibbles; nibble k drives digit k, with [3:0] as digit 0.
REQ-007 load  input  1  request to take value; it is accepted only in a cycle where ready=1.
REQ-008 ready  output  1  high when a new value can be accepted.
REQ-009 blank_lz  input  1  when 1, leading zeros are blanked.
REQ-010 brightness  input  4  duty level; 0 is dimmest (1/16 of the slot) and 15 is full slot.
REQ-011 segment  output  7  active-high segments; bit0=a through bit6=g.
REQ-012 indicator  output  4  active-low digit selects; 4'b1110 selects digit 0.
REQ-013 frame_pulse  output  1  one-cycle pulse at each frame boundary.

Function
REQ-014 The FSM SHALL have two states, BLANK and LIT, plus a 2-bit digit index and a phase counter.
REQ-015 Digits SHALL scan in the order 0,1,2,3,0,...; the index SHALL wrap from 3 to 0.
REQ-016 BLANK SHALL last DEAD_CYCLES cycles, then the FSM SHALL enter LIT for the same digit. LIT SHALL last SLOT_CYCLES cycles, then the FSM SHALL enter BLANK for the next digit. The phase counter SHALL reset to 0 at each state entry.
REQ-017 Every output SHALL be registered. segment, indicator and frame_pulse in cycle n+1 SHALL reflect the FSM state and counters of cycle n.
REQ-018 In BLANK: indicator=4'b1111 and segment=7'h00.
REQ-019 In LIT, the digit SHALL be driven only while phase < (brightness_f+1)*(SLOT_CYCLES/16).
  - When driven: indicator has only bit k low; segment = hex decode of display nibble k.
  - Otherwise: indicator=4'b1111 and segment=7'h00.
REQ-020 brightness_f SHALL be brightness sampled at each frame boundary, and held for the whole frame.
REQ-021 Hex decode SHALL be standard.
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
REQ-022 Leading-zero blanking (blank_lz=1), for digit k≥1: if nibbles k..3 of the display register are all zero, that digit SHALL be treated as not driven. Digit 0 SHALL never be blanked.
REQ-023 A frame boundary SHALL be the last LIT cycle of digit 3. frame_pulse SHALL be 1 in the cycle after it, and 0 at all other times.
REQ-024 load=1 with ready=1 SHALL capture value into a pending register and set pend_valid; ready SHALL be 0 from the next cycle.
REQ-025 load while ready=0 SHALL be ignored, and the pending value SHALL not change.
REQ-026 At a frame boundary with pend_valid=1: pending SHALL be copied to the display register, pend_valid SHALL clear, and ready SHALL return to 1 on the next cycle. The display therefore never changes mid-frame.
REQ-027 A load accepted in the frame-boundary cycle itself SHALL NOT be transferred at that boundary; it SHALL wait for the next boundary.
REQ-028 value, blank_lz and brightness SHALL be ignored outside the sampling points defined above.

Reset
REQ-029 While rst_n=0, the outputs SHALL be forced to:
  - indicator=4'b1111, segment=7'h00, frame_pulse=0, ready=1.
REQ-030 While rst_n=0, the internal state SHALL be forced to:
  - display register=16'h0000, pend_valid=0, brightness_f=4'hF.
  - FSM=BLANK, digit=0, phase=0.
REQ-031 After rst_n rises, the first rising edge SHALL begin BLANK of digit 0. A reset asserted mid-frame or mid-handshake SHALL discard the pending value.

Verification (SLOT_CYCLES=16, DEAD_CYCLES=2, frame = 72 cycles)
REQ-032 Free run after reset, value never loaded → frame_pulse period 72. The pattern per digit is 2 cycles of indicator=1111, then 16 cycles of 1110/1101/1011/0111 with segment=3F.
REQ-033 load value=16'h12AF at mid-frame → ready falls next cycle. Before the boundary the display still shows 3F. From the next frame: digit0=71, digit1=77, digit2=5B, digit3=06; ready rises after the boundary.
REQ-034 load 16'h0005 with blank_lz=1 → digits 3, 2 and 1 read indicator=1111; digit 0 reads 6D. Load 16'h0000 → only digit 0 lit, showing 3F.
REQ-035 brightness=3, sampled at the boundary → in each LIT phase the digit is driven for 4 cycles, then 12 cycles with indicator=1111. Changing brightness mid-frame has no effect until the next frame.
REQ-036 Second load while ready=0 → ignored; the first value is displayed. A load in the boundary cycle transfers one frame later.
REQ-037 rst_n pulsed low mid-LIT with a pending load → outputs take their reset values immediately, and the pending value is never displayed.
